// File: rtl/sort_session_ctrl.sv
// Session sequencer: parses a length-framed request from RX, loads and starts the sorter,
// then streams the length byte and the sorted bytes back out on TX.
//
// state   | meaning
// IDLE    | waiting for a length byte
// LOAD    | writing data bytes into the sorter, idle-timeout armed
// START   | one-cycle sorter start pulse
// WAIT    | waiting for sort_done_i
// HDR     | sending the length byte back
// FETCH   | sorter read address settles, result captured on exit
// SEND    | sending one sorted byte
// ERR     | sending ERR_BYTE after a rejected frame
module sort_session_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter int         ADDR_W         = 4,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ERR_BYTE       = 8'hEE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              sort_wr_en_o,
  output logic [ADDR_W-1:0] sort_wr_addr_o,
  output logic [7:0]        sort_wr_data_o,
  output logic [ADDR_W:0]   sort_len_o,
  output logic              sort_start_o,
  input  logic              sort_done_i,
  output logic [ADDR_W-1:0] sort_rd_addr_o,
  input  logic [7:0]        sort_rd_data_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_HDR, S_FETCH, S_SEND, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                err_q, err_d;

  logic rx_fire, tx_fire, send_adv, wr_last, rd_last, len_ok;

  assign rx_ready_o     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign tx_valid_o     = (state_q == S_HDR) || (state_q == S_SEND) || (state_q == S_ERR);
  assign rx_fire        = rx_valid_i && rx_ready_o;
  assign tx_fire        = tx_valid_o && tx_ready_i;
  assign tx_data_o      = tx_data_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_o          = err_q;
  assign sort_len_o     = len_q;
  assign sort_start_o   = (state_q == S_START);
  assign sort_wr_en_o   = (state_q == S_LOAD) && rx_fire;
  assign sort_wr_addr_o = wr_idx_q;
  assign sort_wr_data_o = rx_data_i;

  // The next read address is presented during the transfer cycle so a registered-read
  // sorter has the byte ready by the end of FETCH.
  assign send_adv       = (state_q == S_SEND) && tx_fire;
  assign sort_rd_addr_o = rd_idx_q + ADDR_W'(send_adv);

  assign len_ok  = (rx_data_i != 8'd0) && (rx_data_i <= MAX_LEN_B);
  assign wr_last = (({1'b0, wr_idx_q} + LEN_ONE) == len_q);
  assign rd_last = ({1'b0, rd_idx_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    to_cnt_d  = to_cnt_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (len_ok) begin
            len_d    = rx_data_i[ADDR_W:0];
            wr_idx_d = '0;
            to_cnt_d = TO_LOAD;
            state_d  = S_LOAD;
          end else begin
            tx_data_d = ERR_BYTE;
            err_d     = 1'b1;
            state_d   = S_ERR;
          end
        end
      end
      S_LOAD: begin
        if (rx_fire) begin
          wr_idx_d = wr_idx_q + IDX_ONE;
          to_cnt_d = TO_LOAD;
          if (wr_last) state_d = S_START;
        end else if (to_cnt_q == '0) begin
          tx_data_d = ERR_BYTE;
          err_d     = 1'b1;
          state_d   = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (sort_done_i) begin
          tx_data_d = 8'(len_q);
          rd_idx_d  = '0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (tx_fire) begin
          rd_idx_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        tx_data_d = sort_rd_data_i;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (tx_fire) begin
          rd_idx_d = rd_idx_q + IDX_ONE;
          state_d  = rd_last ? S_IDLE : S_FETCH;
        end
      end
      S_ERR: begin
        if (tx_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      to_cnt_q  <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      to_cnt_q  <= to_cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
    end
  end

endmodule
